// File: rtl/vga_timing_pkg.sv
// Timing constants, FSM state codes and helpers shared by the VGA capture receiver.
// Defaults describe 640x480@60 on an 800x525 raster.
package vga_timing_pkg;

    localparam int COORD_W      = 11;

    localparam int VGA_SHOW_X_B = 144;
    localparam int VGA_SHOW_X_E = 784;
    localparam int VGA_SHOW_Y_B = 35;
    localparam int VGA_SHOW_Y_E = 515;
    localparam int VGA_TIME_HYS = 800;
    localparam int VGA_TIME_VYS = 525;

    localparam logic [1:0] SEARCH  = 2'd0;
    localparam logic [1:0] MEASURE = 2'd1;
    localparam logic [1:0] LOCKED  = 2'd2;

    // Position counters stick at all-ones so a dead link never wraps back into range.
    function automatic logic [COORD_W-1:0] sat_inc(input logic [COORD_W-1:0] v);
        return (v == {COORD_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/vga_rx_sync_det.sv
// Input register, sync edge detection, raster position counters and line/frame length checks.
// Every output is aligned with the registered pixel rgb_o (stage 1).
module vga_rx_sync_det
    import vga_timing_pkg::*;
#(
    parameter int TIME_HYS = VGA_TIME_HYS,
    parameter int TIME_VYS = VGA_TIME_VYS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hys_i,
    input  logic               vys_i,
    input  logic [15:0]        rgb_i,
    output logic [15:0]        rgb_o,
    output logic [COORD_W-1:0] hcnt_o,
    output logic [COORD_W-1:0] vcnt_o,
    output logic               vrst_o,
    output logic               vfall_o,
    output logic               err_h_o,
    output logic               err_v_o
);

    localparam logic [COORD_W-1:0] H_LAST = COORD_W'(TIME_HYS - 1);
    localparam logic [COORD_W-1:0] V_LAST = COORD_W'(TIME_VYS - 1);

    logic               hys_q, vys_q;
    logic [15:0]        rgb_q;
    logic [COORD_W-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic               pend_q, pend_d;
    logic               hseen_q, vseen_q;
    logic               vrst_q, vfall_q, err_h_q, err_v_q;
    logic               hfall, vfall, vrst;

    assign hfall = hys_q & ~hys_i;
    assign vfall = vys_q & ~vys_i;
    // A vsync fall arriving together with an hsync fall starts the frame on that same line.
    assign vrst  = hfall & (pend_q | vfall);

    always_comb begin
        hcnt_d = hfall ? '0 : sat_inc(hcnt_q);
        vcnt_d = vcnt_q;
        if (hfall) begin
            vcnt_d = vrst ? '0 : sat_inc(vcnt_q);
        end
        pend_d = vrst ? 1'b0 : (pend_q | vfall);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hys_q   <= 1'b0;
            vys_q   <= 1'b0;
            rgb_q   <= '0;
            hcnt_q  <= '0;
            vcnt_q  <= '0;
            pend_q  <= 1'b0;
            hseen_q <= 1'b0;
            vseen_q <= 1'b0;
            vrst_q  <= 1'b0;
            vfall_q <= 1'b0;
            err_h_q <= 1'b0;
            err_v_q <= 1'b0;
        end else begin
            hys_q   <= hys_i;
            vys_q   <= vys_i;
            rgb_q   <= rgb_i;
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
            pend_q  <= pend_d;
            hseen_q <= hseen_q | hfall;
            vseen_q <= vseen_q | vrst;
            vrst_q  <= vrst;
            vfall_q <= vfall;
            // The first line/frame after reset has no known start, so its length is not judged.
            err_h_q <= hfall & hseen_q & (hcnt_q != H_LAST);
            err_v_q <= vrst & vseen_q & (vcnt_q != V_LAST);
        end
    end

    assign rgb_o   = rgb_q;
    assign hcnt_o  = hcnt_q;
    assign vcnt_o  = vcnt_q;
    assign vrst_o  = vrst_q;
    assign vfall_o = vfall_q;
    assign err_h_o = err_h_q;
    assign err_v_o = err_v_q;

endmodule

// File: rtl/vga_rx_capture.sv
// VGA receive capture: lock FSM, active-area decode and output stage on top of vga_rx_sync_det.
// Define VGA_RX_CHECKSUM_EN to add the per-frame pixel checksum output frame_sum.
module vga_rx_capture
    import vga_timing_pkg::*;
#(
    parameter int SHOW_X_B    = VGA_SHOW_X_B,
    parameter int SHOW_X_E    = VGA_SHOW_X_E,
    parameter int SHOW_Y_B    = VGA_SHOW_Y_B,
    parameter int SHOW_Y_E    = VGA_SHOW_Y_E,
    parameter int TIME_HYS    = VGA_TIME_HYS,
    parameter int TIME_VYS    = VGA_TIME_VYS,
    parameter int LOCK_FRAMES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vga_hys,
    input  logic               vga_vys,
    input  logic [15:0]        vga_rgb,
    output logic               pix_en,
    output logic [15:0]        pix_data,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic               frame_start,
    output logic               frame_done,
    output logic               locked,
`ifdef VGA_RX_CHECKSUM_EN
    output logic [15:0]        frame_sum,
`endif
    output logic               err_h,
    output logic               err_v
);

    localparam logic [COORD_W-1:0] X_B    = COORD_W'(SHOW_X_B);
    localparam logic [COORD_W-1:0] X_E    = COORD_W'(SHOW_X_E);
    localparam logic [COORD_W-1:0] Y_B    = COORD_W'(SHOW_Y_B);
    localparam logic [COORD_W-1:0] Y_E    = COORD_W'(SHOW_Y_E);
    localparam logic [3:0]         LOCK_N = 4'(LOCK_FRAMES);

    logic [15:0]        rgb_s;
    logic [COORD_W-1:0] hcnt, vcnt;
    logic               vrst_s, vfall_s, err_h_s, err_v_s, any_err;

    vga_rx_sync_det #(
        .TIME_HYS (TIME_HYS),
        .TIME_VYS (TIME_VYS)
    ) u_sync_det (
        .clk     (clk),
        .rst     (rst),
        .hys_i   (vga_hys),
        .vys_i   (vga_vys),
        .rgb_i   (vga_rgb),
        .rgb_o   (rgb_s),
        .hcnt_o  (hcnt),
        .vcnt_o  (vcnt),
        .vrst_o  (vrst_s),
        .vfall_o (vfall_s),
        .err_h_o (err_h_s),
        .err_v_o (err_v_s)
    );

    assign any_err = err_h_s | err_v_s;

    logic [1:0] state_q, state_d;
    logic [3:0] good_q, good_d;
    logic       bad_q, bad_d;

    // A frame is clean only if no error hit it, including one coinciding with its end.
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        bad_d   = bad_q | any_err;
        case (state_q)
            SEARCH: begin
                if (vrst_s) begin
                    state_d = MEASURE;
                    good_d  = '0;
                    bad_d   = 1'b0;
                end
            end
            MEASURE: begin
                if (vrst_s) begin
                    bad_d = 1'b0;
                    if (bad_q | any_err) begin
                        good_d = '0;
                    end else begin
                        good_d = good_q + 4'd1;
                        if (good_d == LOCK_N) begin
                            state_d = LOCKED;
                        end
                    end
                end else if (any_err) begin
                    good_d = '0;
                end
            end
            LOCKED: begin
                if (any_err) begin
                    state_d = SEARCH;
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    logic active, frame_done_d;
    logic pix_en_q, frame_start_q, frame_done_q;
    logic [15:0]        pix_data_q;
    logic [COORD_W-1:0] pix_x_q, pix_y_q;

    assign active = (hcnt >= X_B) && (hcnt < X_E) && (vcnt >= Y_B) && (vcnt < Y_E)
                  && (state_q == LOCKED);
    assign frame_done_d = vfall_s && (state_q == LOCKED) && !any_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= SEARCH;
            good_q        <= '0;
            bad_q         <= 1'b0;
            pix_en_q      <= 1'b0;
            pix_data_q    <= '0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            good_q        <= good_d;
            bad_q         <= bad_d;
            pix_en_q      <= active;
            pix_data_q    <= active ? rgb_s : '0;
            pix_x_q       <= active ? hcnt - X_B : '0;
            pix_y_q       <= active ? vcnt - Y_B : '0;
            frame_start_q <= active && (hcnt == X_B) && (vcnt == Y_B);
            frame_done_q  <= frame_done_d;
        end
    end

`ifdef VGA_RX_CHECKSUM_EN
    logic [15:0] acc_q, sum_q;

    // Loading the first pixel on frame_start doubles as the per-frame clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            sum_q <= '0;
        end else begin
            if (frame_start_q) begin
                acc_q <= pix_data_q;
            end else if (pix_en_q) begin
                acc_q <= acc_q + pix_data_q;
            end
            if (frame_done_d) begin
                sum_q <= acc_q;
            end
        end
    end

    assign frame_sum = sum_q;
`endif

    assign pix_en      = pix_en_q;
    assign pix_data    = pix_data_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;
    assign locked      = (state_q == LOCKED);
    assign err_h       = err_h_s;
    assign err_v       = err_v_s;

endmodule

// File: tb/tb_vga_rx_capture.sv
// Directed bench for vga_rx_capture on a reduced 32x10 raster (16x4 active) to keep runs short.
// Covers lock, pixel coordinates/data, latency, line/frame errors, lock race and mid-frame reset.
module tb_vga_rx_capture;

    localparam int XB = 8;
    localparam int XE = 24;
    localparam int YB = 3;
    localparam int YE = 7;
    localparam int TH = 32;
    localparam int TV = 10;
    localparam int LF = 2;
    localparam int W  = XE - XB;
    localparam int H  = YE - YB;
    localparam int HS_LEN = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vga_hys = 1'b1;
    logic        vga_vys = 1'b1;
    logic [15:0] vga_rgb = '0;
    logic        pix_en, frame_start, frame_done, locked, err_h, err_v;
    logic [15:0] pix_data;
    logic [10:0] pix_x, pix_y;
`ifdef VGA_RX_CHECKSUM_EN
    logic [15:0] frame_sum;
`endif

    vga_rx_capture #(
        .SHOW_X_B    (XB),
        .SHOW_X_E    (XE),
        .SHOW_Y_B    (YB),
        .SHOW_Y_E    (YE),
        .TIME_HYS    (TH),
        .TIME_VYS    (TV),
        .LOCK_FRAMES (LF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .vga_hys     (vga_hys),
        .vga_vys     (vga_vys),
        .vga_rgb     (vga_rgb),
        .pix_en      (pix_en),
        .pix_data    (pix_data),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .locked      (locked),
`ifdef VGA_RX_CHECKSUM_EN
        .frame_sum   (frame_sum),
`endif
        .err_h       (err_h),
        .err_v       (err_v)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    function automatic logic [15:0] pat(input logic [10:0] x, input logic [10:0] y);
        return {x[4:0], y[5:0], x[4:0]};
    endfunction

    task automatic check_quiet(input string tag);
        check_eq({tag, "_flags"}, {26'd0, pix_en, frame_start, frame_done, locked, err_h, err_v}, 32'd0);
        check_eq({tag, "_xy"}, {10'd0, pix_x, pix_y}, 32'd0);
        check_eq({tag, "_data"}, {16'd0, pix_data}, 32'd0);
    endtask

    bit          mon_on = 1'b0;
    int          pcnt = 0, pix_total = 0, fs_cnt = 0, fd_cnt = 0;
    int          eh_cnt = 0, ev_cnt = 0, idle_bad = 0, rec_cyc = 0;
    logic [15:0] msum = '0;

    // Output monitor: raster-order scoreboard of expected pixel coordinates and data.
    initial begin
        logic        err_prev;
        int          ex, ey;
        logic [10:0] exv, eyv;
        err_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                if (err_prev) check_eq("lock_drop", {31'd0, locked}, 32'd0);
                err_prev = err_h | err_v;
                if (err_h) eh_cnt++;
                if (err_v) ev_cnt++;
                if (frame_start) begin
                    fs_cnt++;
                    check_eq("fs_latency", cyc - rec_cyc, 32'd2);
                    pcnt = 0;
                    msum = '0;
                end
                if (pix_en) begin
                    ex  = pcnt % W;
                    ey  = pcnt / W;
                    exv = 11'(ex);
                    eyv = 11'(ey);
                    check_eq("pix_x", {21'd0, pix_x}, ex);
                    check_eq("pix_y", {21'd0, pix_y}, ey);
                    check_eq("pix_data", {16'd0, pix_data}, {16'd0, pat(exv, eyv)});
                    check_eq("fs_flag", {31'd0, frame_start}, {31'd0, (pcnt == 0)});
                    msum = msum + pat(exv, eyv);
                    pcnt++;
                    pix_total++;
                end else if (frame_start || pix_x != 0 || pix_y != 0 || pix_data != 0) begin
                    idle_bad++;
                end
                if (frame_done) begin
                    fd_cnt++;
                    check_eq("frame_px", pcnt, W * H);
`ifdef VGA_RX_CHECKSUM_EN
                    check_eq("frame_sum", {16'd0, frame_sum}, {16'd0, msum});
`endif
                    pcnt = 0;
                end
            end
        end
    end

    // One frame of ideal sync; optional short line and a one-clock reset at (rst_line, rst_col).
    task automatic drive_frame(input int nlines, input int short_line, input int rst_line,
                               input int rst_col);
        int          len;
        logic [10:0] xv, yv;
        for (int l = 0; l < nlines; l++) begin
            len = (l == short_line) ? TH - 1 : TH;
            for (int c = 0; c < len; c++) begin
                @(posedge clk);
                #1;
                if (l == rst_line && c == rst_col + 1) check_quiet("midrst");
                rst     = (l == rst_line && c == rst_col);
                vga_hys = (c < HS_LEN) ? 1'b0 : 1'b1;
                vga_vys = (l < 2) ? 1'b0 : 1'b1;
                xv      = 11'(c - XB);
                yv      = 11'(l - YB);
                vga_rgb = pat(xv, yv);
                if (l == YB && c == XB) rec_cyc = cyc;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            vga_hys = 1'b1;
            vga_vys = 1'b1;
        end
    endtask

    initial begin
        int mark;
        repeat (3) @(posedge clk);
        #1;
        check_quiet("reset");
        rst    = 1'b0;
        mon_on = 1'b1;
        idle(4);

        drive_frame(TV, -1, -1, -1);
        drive_frame(TV, -1, -1, -1);
        check_eq("lock_f2", {31'd0, locked}, 32'd0);
        check_eq("pix_before_lock", pix_total, 32'd0);
        drive_frame(TV, -1, -1, -1);
        check_eq("lock_f3", {31'd0, locked}, 32'd1);
        drive_frame(TV, -1, -1, -1);

        drive_frame(TV, 5, -1, -1);
        check_eq("unlock_h", {31'd0, locked}, 32'd0);
        check_eq("err_h_cnt", eh_cnt, 32'd1);
        mark = pix_total;
        drive_frame(TV, -1, -1, -1);
        drive_frame(TV, -1, -1, -1);
        check_eq("gap_h", pix_total - mark, 32'd0);
        check_eq("relock_h_wait", {31'd0, locked}, 32'd0);

        drive_frame(TV - 1, -1, -1, -1);
        check_eq("lock_f8", {31'd0, locked}, 32'd1);
        drive_frame(TV, -1, -1, -1);
        check_eq("unlock_v", {31'd0, locked}, 32'd0);
        check_eq("err_v_cnt", ev_cnt, 32'd1);
        check_eq("fd_no_err_frame", fd_cnt, 32'd2);

        drive_frame(TV, -1, -1, -1);
        drive_frame(TV - 1, -1, -1, -1);
        drive_frame(TV, -1, -1, -1);
        check_eq("race_lock", {31'd0, locked}, 32'd0);
        check_eq("err_v_cnt2", ev_cnt, 32'd2);
        drive_frame(TV, -1, -1, -1);
        check_eq("race_wait", {31'd0, locked}, 32'd0);
        drive_frame(TV, -1, -1, -1);
        check_eq("lock_f14", {31'd0, locked}, 32'd1);

        drive_frame(TV, -1, 5, 12);
        mark = pix_total;
        drive_frame(TV, -1, -1, -1);
        drive_frame(TV, -1, -1, -1);
        check_eq("gap_rst", pix_total - mark, 32'd0);
        check_eq("relock_rst_wait", {31'd0, locked}, 32'd0);
        drive_frame(TV, -1, -1, -1);
        check_eq("lock_f18", {31'd0, locked}, 32'd1);

        drive_frame(2, -1, -1, -1);
        idle(8);
        check_eq("fs_total", fs_cnt, 32'd7);
        check_eq("fd_total", fd_cnt, 32'd4);
        check_eq("err_h_total", eh_cnt, 32'd1);
        check_eq("err_v_total", ev_cnt, 32'd2);
        check_eq("idle_zero", idle_bad, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
